// File: rtl/cycle_profiler_if.sv
// Control/result bundle of the cycle profiler: stimulus from the operation
// under test, RAM write port toward the shared data RAM, and status flags.
interface cycle_profiler_if #(
    parameter int CNT_W = 33
);
    logic             start;
    logic             op_done;
    logic [8:0]       write_address;
    logic [63:0]      write_data;
    logic             write_en;
    logic [CNT_W-1:0] last_count;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, op_done,
        input  write_address, write_data, write_en, last_count, busy, done, overflow
    );
    modport slave (
        input  start, op_done,
        output write_address, write_data, write_en, last_count, busy, done, overflow
    );
endinterface

// File: rtl/cycle_profiler.sv
// Counts cycles from a start pulse to op_done and stores the count (or the
// worst case seen so far) in RAM word WR_ADDR for the constant-time delay loop.
module cycle_profiler #(
    parameter logic [8:0] WR_ADDR   = 9'd0,
    parameter int         CNT_W     = 33,
    parameter bit         TRACK_MAX = 1'b1
) (
    input logic            clk,
    input logic            rst,
    cycle_profiler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, WRITE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [CNT_W-1:0] counter_q, max_q, last_q;
    logic [CNT_W-1:0] counter_d, peak_d;
    logic [63:0]      wdata_q;
    logic             wen_q, busy_q, done_q, ovf_q;
    logic             sat;

    // write_data is registered on the edge entering WRITE, so it is built
    // from the counter value that WRITE will hold.
    always_comb begin
        sat       = (counter_q == CNT_MAX);
        counter_d = sat ? counter_q : counter_q + 1'b1;
        peak_d    = (TRACK_MAX && (max_q > counter_d)) ? max_q : counter_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            max_q     <= '0;
            last_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q   <= COUNT;
                        counter_q <= '0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                COUNT: begin
                    counter_q <= counter_d;
                    if (sat) ovf_q <= 1'b1;
                    if (bus.op_done) begin
                        state_q <= WRITE;
                        wen_q   <= 1'b1;
                        wdata_q <= 64'(peak_d);
                    end
                end
                WRITE: begin
                    last_q <= counter_q;
                    if (counter_q > max_q) max_q <= counter_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.write_address = WR_ADDR;
    assign bus.write_data    = wdata_q;
    assign bus.write_en      = wen_q;
    assign bus.last_count    = last_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_cycle_profiler.sv
// Bench for cycle_profiler: a wide max-tracking instance and a 4-bit
// latest-count instance driven by the same start/op_done stimulus.
module tb_cycle_profiler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic op_done = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   wen0 = 0;
    int   wen1 = 0;
    longint unsigned max0 = 0;

    always #5 clk = ~clk;

    cycle_profiler_if #(.CNT_W(33)) b0 ();
    cycle_profiler_if #(.CNT_W(4))  b1 ();

    assign b0.start   = start;
    assign b0.op_done = op_done;
    assign b1.start   = start;
    assign b1.op_done = op_done;

    cycle_profiler #(.WR_ADDR(9'd0), .CNT_W(33), .TRACK_MAX(1'b1)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    cycle_profiler #(.WR_ADDR(9'd3), .CNT_W(4), .TRACK_MAX(1'b0)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    always @(negedge clk) begin
        if (b0.write_en) wen0++;
        if (b1.write_en) wen1++;
    end

    typedef struct {
        int              k;
        longint unsigned d0;   // expected data, wide max-tracking instance
        int              d1;   // expected data, 4-bit latest-count instance
        bit              ov1;
    } vec_t;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy0"}, 64'(b0.busy), 0);
        chk({tag, "_done0"}, 64'(b0.done), 0);
        chk({tag, "_wen0"},  64'(b0.write_en), 0);
        chk({tag, "_data0"}, b0.write_data, 0);
        chk({tag, "_last0"}, 64'(b0.last_count), 0);
        chk({tag, "_ovf0"},  64'(b0.overflow), 0);
        chk({tag, "_data1"}, b1.write_data, 0);
        chk({tag, "_ovf1"},  64'(b1.overflow), 0);
    endtask

    // One measured run of k cycles with expected results supplied by the caller.
    task automatic run(input int k, input bit op_early, input bit start_mid,
                       input longint unsigned e0, input int e1, input bit ov1);
        int w0s, w1s;
        w0s = wen0;
        w1s = wen1;
        start = 1'b1;
        op_done = op_early;
        cyc();
        start = 1'b0;
        chk("busy_after_start", 64'(b0.busy), 1);
        chk("done_after_start", 64'(b0.done), 0);
        for (int i = 1; i < k; i++) begin
            start = start_mid && (i == 2);
            cyc();
        end
        start = 1'b0;
        op_done = 1'b1;
        cyc();
        op_done = 1'b0;
        chk("wen0", 64'(b0.write_en), 1);
        chk("wen1", 64'(b1.write_en), 1);
        chk("addr0", 64'(b0.write_address), 0);
        chk("addr1", 64'(b1.write_address), 3);
        chk("data0", b0.write_data, e0);
        chk("data1", b1.write_data, 64'(e1));
        chk("busy_write", 64'(b0.busy), 1);
        cyc();
        chk("wen0_off", 64'(b0.write_en), 0);
        chk("done0", 64'(b0.done), 1);
        chk("done1", 64'(b1.done), 1);
        chk("busy_done", 64'(b0.busy), 0);
        chk("last0", 64'(b0.last_count), 64'(k));
        chk("last1", 64'(b1.last_count), 64'(e1));
        chk("hold_data0", b0.write_data, e0);
        chk("wen0_pulses", 64'(wen0 - w0s), 1);
        chk("wen1_pulses", 64'(wen1 - w1s), 1);
        chk("ovf0", 64'(b0.overflow), 0);
        // k==15 exactly reaches the ceiling without an increment being lost
        if (k != 15) chk("ovf1", 64'(b1.overflow), 64'(ov1));
    endtask

    // Expected values derived from the run length alone.
    task automatic run_model(input int k, input bit op_early, input bit start_mid);
        longint unsigned e0;
        int e1;
        e0 = (64'(k) > max0) ? 64'(k) : max0;
        max0 = e0;
        e1 = (k > 15) ? 15 : k;
        run(k, op_early, start_mid, e0, e1, k > 15);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{k: 5,  d0: 5,  d1: 5,  ov1: 1'b0};
        tbl[1] = '{k: 10, d0: 10, d1: 10, ov1: 1'b0};
        tbl[2] = '{k: 4,  d0: 10, d1: 4,  ov1: 1'b0};
        tbl[3] = '{k: 12, d0: 12, d1: 12, ov1: 1'b0};
        tbl[4] = '{k: 20, d0: 20, d1: 15, ov1: 1'b1};
        tbl[5] = '{k: 3,  d0: 20, d1: 3,  ov1: 1'b0};

        #1;
        chk_idle_zero("reset");
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // op_done alone in IDLE must not start anything
        op_done = 1'b1;
        cyc();
        op_done = 1'b0;
        cyc();
        chk("idle_opdone_busy", 64'(b0.busy), 0);
        chk("idle_opdone_wen", 64'(wen0), 0);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].k, 1'b0, 1'b0, tbl[i].d0, tbl[i].d1, tbl[i].ov1);
            if (64'(tbl[i].k) > max0) max0 = 64'(tbl[i].k);
        end

        // Reset three cycles into an eight-cycle run
        begin
            int ws;
            ws = wen0;
            start = 1'b1;
            cyc();
            start = 1'b0;
            cyc();
            cyc();
            rst = 1'b1;
            #1;
            chk_idle_zero("midrst");
            cyc();
            rst = 1'b0;
            max0 = 0;
            op_done = 1'b1;
            cyc();
            op_done = 1'b0;
            chk("midrst_no_write", 64'(wen0 - ws), 0);
        end
        run_model(7, 1'b0, 1'b0);

        // start with op_done in the same IDLE cycle, held high -> count 1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        max0 = 0;
        run_model(1, 1'b1, 1'b0);
        // start pulses during COUNT are ignored; start in DONE restarts
        run_model(9, 1'b0, 1'b1);
        run_model(6, 1'b0, 1'b1);

        for (int n = 0; n < 20; n++) begin
            int k;
            bit sm, oe;
            k  = int'($urandom_range(1, 40));
            sm = 1'($urandom_range(0, 1));
            oe = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_model(k, oe, sm);
            if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 3))) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
